dec_scan_sel: RTL and testbench
===============================

# dec_scan_sel

Parametrised, registered N-to-2^N one-hot decoder with active-low enable and an auto-scan mode. In direct mode it decodes the external address; in scan mode an internal prescaler steps the selected output through all 2^N lines cyclically. It drives multiplexed loads such as display digit anodes or row strobes, and replaces the fixed 1-of-4 combinational decoder wherever a wider or time-multiplexed select is needed.

## Interface
- N, default 2: address width; the block has 2^N outputs.
- PRESC_W, default 16: width of the prescaler counter and of `presc`.
- ACTIVE_LOW_OUT, default 0: 1 inverts every bit of `b`, so the selected line is 0 and idle lines are 1.

Ports:
- clk  in  1  single system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- en_n  in  1  active-low enable; 1 forces all outputs inactive and freezes state.
- mode  in  1  0 = direct decode, 1 = auto-scan.
- a  in  N  address used in direct mode; bit 0 is the LSB.
- presc  in  PRESC_W  scan step period minus one, in clk cycles.
- b  out  2^N  one-hot select; bit i is active when `sel` = i.
- sel  out  N  currently selected index (registered).
- wrap  out  1  one-cycle pulse marking the scan wrap from 2^N-1 to 0.

## Operation
- State: `sel` register (N bits), prescaler `cnt` (PRESC_W bits), `b` register, `wrap` register.
- Reset (rst=1, asynchronous): `sel`=0, `cnt`=0, `wrap`=0, `b`=all inactive (0s, or all 1s when ACTIVE_LOW_OUT=1).
- en_n=1: `sel` and `cnt` hold, `b` is all inactive on the next edge, and `wrap`=0.
- Direct mode (mode=0, en_n=0): `sel` <= `a` and `cnt` <= 0 every edge.
- Scan mode (mode=1, en_n=0):
  - If `cnt` >= `presc`: `cnt` <= 0 and `sel` <= `sel`+1, modulo 2^N.
  - Otherwise `cnt` <= `cnt`+1 and `sel` holds.
  - The comparison is >= so that lowering `presc` mid-count takes effect immediately with no long rollover.
  - `presc`=0 advances `sel` every cycle.
- `wrap` <= 1 for exactly one cycle on the edge where scan mode advances `sel` from 2^N-1 to 0. It is never asserted in direct mode.
- `b` <= onehot(next `sel`) when en_n=0, otherwise all inactive. `b` and `sel` are always mutually consistent in the same cycle.
- Mode switch direct→scan: scanning continues from the current `sel` with `cnt` starting at 0. The first step occurs `presc`+1 cycles after the switch edge.
- Mode switch scan→direct: `sel` <= `a` on the first edge and the count is discarded.
- en_n deasserted (1→0) in scan mode: resumes from the frozen `sel`/`cnt`; there is no restart.
- At most one bit of `b` is ever active; a glitch-free registered output is required.

## Timing
- Direct-mode latency: `a` is sampled at edge k; `b`/`sel` are valid after edge k, i.e. 1 cycle.
- en_n effect: 1 cycle to blank or unblank `b`.
- Scan dwell: each index stays active for exactly `presc`+1 cycles, provided `presc` is stable. A full scan takes 2^N·(`presc`+1) cycles.
- `wrap` is coincident with the cycle in which `sel`=0 is first presented after the wrap.
- Reset asserts with no clock. On release, the first active edge behaves as a normal edge from the reset state.
- Reset mid-scan returns to `sel`=0, `cnt`=0; a `wrap` pulse in flight is cleared.

## Test plan
- N=2, direct mode, en_n=0, `a` sweeps 0,1,2,3 one per cycle → `b` = 0001, 0010, 0100, 1000 one cycle late; with en_n=1, `b`=0000 regardless of `a`.
- N=2, scan mode, `presc`=2 → `sel` follows 0,0,0,1,1,1,2,2,2,3,3,3,0. `wrap` is high only in the first cycle with `sel`=0 after 3, every 12 cycles.
- N=3, scan mode, `presc`=0 → `sel` increments every cycle 0..7..0 and `b` walks 00000001..10000000. `wrap` has period 8.
- N=2, scan mode, `presc`=9 with `cnt`=6, then `presc` changes to 3 → `sel` advances on the next edge and the dwell becomes 4 cycles thereafter.
- ACTIVE_LOW_OUT=1, N=2: reset gives `b`=1111. In direct mode with `a`=2, `b`=1011; with en_n=1, `b`=1111.
- In scan mode at `sel`=3, assert rst asynchronously between edges → `b`, `sel`, `cnt` and `wrap` clear immediately, and no `wrap` pulse appears after release.

Source files
------------

// File: rtl/dec_scan_sel.sv
// dec_scan_sel: registered N-to-2^N one-hot decoder with active-low enable
// and an auto-scan mode.
//
// In direct mode (mode=0) the external address `a` is registered into `sel`
// and decoded onto `b`. In scan mode (mode=1) an internal prescaler steps
// `sel` through all 2^N lines. Each index dwells for `presc`+1 cycles.
//
// Parameters:
//   N              address width; the block has 2^N outputs
//   PRESC_W        width of the prescaler counter and of `presc`
//   ACTIVE_LOW_OUT 1 inverts every bit of `b` (selected line low)
//
// Ports:
//   clk    in   system clock, rising edge
//   rst    in   asynchronous active-high reset
//   en_n   in   active-low enable; 1 blanks `b` and freezes sel/cnt
//   mode   in   0 = direct decode, 1 = auto-scan
//   a      in   [N-1:0]       direct-mode address
//   presc  in   [PRESC_W-1:0] scan step period minus one
//   b      out  [2^N-1:0]     registered one-hot select
//   sel    out  [N-1:0]       registered selected index
//   wrap   out  one-cycle pulse when the scan wraps from 2^N-1 to 0
module dec_scan_sel #(
  parameter int N              = 2,
  parameter int PRESC_W        = 16,
  parameter int ACTIVE_LOW_OUT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_n,
  input  logic               mode,
  input  logic [N-1:0]       a,
  input  logic [PRESC_W-1:0] presc,
  output logic [(1<<N)-1:0]  b,
  output logic [N-1:0]       sel,
  output logic               wrap
);

  localparam int M = 1 << N;

  // Inactive level of every output line. XOR with this also applies the
  // output polarity to a one-hot word.
  localparam logic [M-1:0] IDLE = (ACTIVE_LOW_OUT != 0) ? {M{1'b1}} : {M{1'b0}};

  localparam logic [N-1:0] SEL_LAST = {N{1'b1}};

  // One-hot decode of an index, active-high.
  function automatic logic [M-1:0] onehot(input logic [N-1:0] idx);
    logic [M-1:0] v;
    v      = {M{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  logic [N-1:0]       sel_r;
  logic [N-1:0]       sel_nxt;
  logic [PRESC_W-1:0] cnt_r;
  logic [PRESC_W-1:0] cnt_nxt;
  logic [M-1:0]       b_r;
  logic [M-1:0]       b_nxt;
  logic               wrap_r;
  logic               wrap_nxt;

  // Next-state logic for the index, prescaler, decoded output and wrap flag.
  always_comb begin
    sel_nxt  = sel_r;
    cnt_nxt  = cnt_r;
    wrap_nxt = 1'b0;
    b_nxt    = IDLE;

    if (en_n) begin
      // Disabled: state frozen so a later enable resumes the scan in place.
      sel_nxt = sel_r;
      cnt_nxt = cnt_r;
    end else if (!mode) begin
      // Direct: follow the address; the count restarts on any switch to scan.
      sel_nxt = a;
      cnt_nxt = {PRESC_W{1'b0}};
    end else if (cnt_r >= presc) begin
      // >= rather than == so a lowered presc takes effect at once instead
      // of waiting for the counter to roll over.
      cnt_nxt  = {PRESC_W{1'b0}};
      sel_nxt  = sel_r + N'(1);
      wrap_nxt = (sel_r == SEL_LAST);
    end else begin
      cnt_nxt = cnt_r + PRESC_W'(1);
    end

    // Decode the next index so b and sel always change on the same edge.
    if (en_n) begin
      b_nxt = IDLE;
    end else begin
      b_nxt = onehot(sel_nxt) ^ IDLE;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_r  <= {N{1'b0}};
      cnt_r  <= {PRESC_W{1'b0}};
      b_r    <= IDLE;
      wrap_r <= 1'b0;
    end else begin
      sel_r  <= sel_nxt;
      cnt_r  <= cnt_nxt;
      b_r    <= b_nxt;
      wrap_r <= wrap_nxt;
    end
  end

  assign b    = b_r;
  assign sel  = sel_r;
  assign wrap = wrap_r;

endmodule

// File: tb/tb_dec_scan_sel.sv
// Self-checking bench for dec_scan_sel: three instances (N=2, N=3, and
// N=2 with inverted outputs) exercised by directed scenarios plus a
// randomized run checked against a rule-level reference model.
module tb_dec_scan_sel;

  logic clk;
  logic rst;

  // N=2 instance
  logic        en_n2, mode2, wrap2;
  logic [1:0]  a2, sel2;
  logic [15:0] presc2;
  logic [3:0]  b2;

  // N=3 instance
  logic        en_n3, mode3, wrap3;
  logic [2:0]  a3, sel3;
  logic [15:0] presc3;
  logic [7:0]  b3;

  // N=2, active-low outputs
  logic        en_nl, model, wrapl;
  logic [1:0]  al, sell;
  logic [15:0] prescl;
  logic [3:0]  bl;

  int errors = 0;
  int checks = 0;

  dec_scan_sel #(.N(2), .PRESC_W(16), .ACTIVE_LOW_OUT(0)) u_dut2 (
    .clk(clk), .rst(rst), .en_n(en_n2), .mode(mode2), .a(a2), .presc(presc2),
    .b(b2), .sel(sel2), .wrap(wrap2));

  dec_scan_sel #(.N(3), .PRESC_W(16), .ACTIVE_LOW_OUT(0)) u_dut3 (
    .clk(clk), .rst(rst), .en_n(en_n3), .mode(mode3), .a(a3), .presc(presc3),
    .b(b3), .sel(sel3), .wrap(wrap3));

  dec_scan_sel #(.N(2), .PRESC_W(16), .ACTIVE_LOW_OUT(1)) u_dutl (
    .clk(clk), .rst(rst), .en_n(en_nl), .mode(model), .a(al), .presc(prescl),
    .b(bl), .sel(sell), .wrap(wrapl));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one active edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++; if (b2 !== 4'b0000) begin errors++; $display("FAIL reset_b2 got=%b exp=%b", b2, 4'b0000); end
    checks++; if (sel2 !== 2'd0) begin errors++; $display("FAIL reset_sel2 got=%0d exp=0", sel2); end
    checks++; if (wrap2 !== 1'b0) begin errors++; $display("FAIL reset_wrap2 got=%b exp=0", wrap2); end
    checks++; if (b3 !== 8'h00) begin errors++; $display("FAIL reset_b3 got=%b exp=%b", b3, 8'h00); end
    checks++; if (bl !== 4'b1111) begin errors++; $display("FAIL reset_bl got=%b exp=1111", bl); end
    tick();
    rst = 1'b0;
    tick();
    // Still disabled after release: nothing may come alive.
    checks++; if (b2 !== 4'b0000) begin errors++; $display("FAIL post_reset_b2 got=%b exp=0000", b2); end
    checks++; if (bl !== 4'b1111) begin errors++; $display("FAIL post_reset_bl got=%b exp=1111", bl); end
  endtask

  task automatic test_direct();
    en_n2 = 1'b0; mode2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a2 = 2'(i);
      tick();
      checks++; if (b2 !== 4'(1 << i)) begin errors++; $display("FAIL direct_b a=%0d got=%b exp=%b", i, b2, 4'(1 << i)); end
      checks++; if (sel2 !== 2'(i)) begin errors++; $display("FAIL direct_sel got=%0d exp=%0d", sel2, i); end
      checks++; if (wrap2 !== 1'b0) begin errors++; $display("FAIL direct_wrap got=%b exp=0", wrap2); end
    end
    en_n2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a2 = 2'($urandom_range(0, 3));
      tick();
      checks++; if (b2 !== 4'b0000) begin errors++; $display("FAIL disabled_b got=%b exp=0000", b2); end
    end
  endtask

  // Scan from index 0 with cnt cleared: after the k-th scan edge the index
  // is floor(k/(p+1)) mod M, and wrap fires on every full period.
  task automatic test_scan_n2_p2();
    int p;
    int exp_sel;
    p = 2;
    en_n2 = 1'b0; mode2 = 1'b0; a2 = 2'd0;
    tick();
    mode2 = 1'b1; presc2 = 16'(p);
    for (int k = 1; k <= 26; k++) begin
      tick();
      exp_sel = (k / (p + 1)) % 4;
      checks++; if (sel2 !== 2'(exp_sel)) begin errors++; $display("FAIL scan2_sel k=%0d got=%0d exp=%0d", k, sel2, exp_sel); end
      checks++; if (b2 !== 4'(1 << exp_sel)) begin errors++; $display("FAIL scan2_b k=%0d got=%b exp=%b", k, b2, 4'(1 << exp_sel)); end
      checks++; if (wrap2 !== ((k % (4 * (p + 1))) == 0)) begin errors++; $display("FAIL scan2_wrap k=%0d got=%b", k, wrap2); end
    end
  endtask

  task automatic test_scan_n3_p0();
    int exp_sel;
    en_n3 = 1'b0; mode3 = 1'b0; a3 = 3'd0; presc3 = 16'd0;
    tick();
    mode3 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp_sel = k % 8;
      checks++; if (sel3 !== 3'(exp_sel)) begin errors++; $display("FAIL scan3_sel k=%0d got=%0d exp=%0d", k, sel3, exp_sel); end
      checks++; if (b3 !== 8'(1 << exp_sel)) begin errors++; $display("FAIL scan3_b k=%0d got=%b exp=%b", k, b3, 8'(1 << exp_sel)); end
      checks++; if (wrap3 !== (exp_sel == 0)) begin errors++; $display("FAIL scan3_wrap k=%0d got=%b", k, wrap3); end
    end
  endtask

  task automatic test_presc_change();
    int exp_sel;
    en_n2 = 1'b0; mode2 = 1'b0; a2 = 2'd0;
    tick();
    mode2 = 1'b1; presc2 = 16'd9;
    for (int k = 1; k <= 6; k++) tick();  // cnt reaches 6
    checks++; if (sel2 !== 2'd0) begin errors++; $display("FAIL presc_pre_sel got=%0d exp=0", sel2); end
    presc2 = 16'd3;
    for (int k = 1; k <= 9; k++) begin
      tick();
      // Step on the first edge, then every 4 edges.
      exp_sel = 1 + (k - 1) / 4;
      checks++; if (sel2 !== 2'(exp_sel)) begin errors++; $display("FAIL presc_chg_sel k=%0d got=%0d exp=%0d", k, sel2, exp_sel); end
    end
  endtask

  task automatic test_active_low();
    en_nl = 1'b0; model = 1'b0; al = 2'd2;
    tick();
    checks++; if (bl !== 4'b1011) begin errors++; $display("FAIL actlow_b got=%b exp=1011", bl); end
    checks++; if (sell !== 2'd2) begin errors++; $display("FAIL actlow_sel got=%0d exp=2", sell); end
    en_nl = 1'b1;
    tick();
    checks++; if (bl !== 4'b1111) begin errors++; $display("FAIL actlow_dis got=%b exp=1111", bl); end
  endtask

  task automatic test_async_reset();
    int exp_sel;
    en_n2 = 1'b0; mode2 = 1'b0; a2 = 2'd0;
    tick();
    mode2 = 1'b1; presc2 = 16'd0;
    for (int k = 1; k <= 3; k++) tick();
    checks++; if (sel2 !== 2'd3) begin errors++; $display("FAIL areset_pre_sel got=%0d exp=3", sel2); end
    #2 rst = 1'b1;
    #1;
    checks++; if (sel2 !== 2'd0) begin errors++; $display("FAIL areset_sel got=%0d exp=0", sel2); end
    checks++; if (b2 !== 4'b0000) begin errors++; $display("FAIL areset_b got=%b exp=0000", b2); end
    checks++; if (wrap2 !== 1'b0) begin errors++; $display("FAIL areset_wrap got=%b exp=0", wrap2); end
    #1 rst = 1'b0;
    presc2 = 16'd2;
    // cnt must have cleared: first step three edges after release.
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_sel = k / 3;
      checks++; if (sel2 !== 2'(exp_sel)) begin errors++; $display("FAIL areset_post_sel k=%0d got=%0d exp=%0d", k, sel2, exp_sel); end
      checks++; if (wrap2 !== 1'b0) begin errors++; $display("FAIL areset_post_wrap k=%0d got=%b exp=0", k, wrap2); end
    end
  endtask

  // Random mix of enable, mode, address and presc against a rule model.
  task automatic test_random();
    int m_sel, m_cnt, m_wrap;
    logic [3:0] exp_b;
    en_n2 = 1'b1;
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    m_sel = 0; m_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      en_n2  = ($urandom_range(0, 4) == 0);
      mode2  = ($urandom_range(0, 3) != 0);
      a2     = 2'($urandom_range(0, 3));
      presc2 = 16'($urandom_range(0, 3));
      m_wrap = 0;
      if (en_n2) begin
        // frozen
      end else if (!mode2) begin
        m_sel = a2; m_cnt = 0;
      end else if (m_cnt >= presc2) begin
        m_cnt = 0;
        m_wrap = (m_sel == 3);
        m_sel = (m_sel + 1) % 4;
      end else begin
        m_cnt = m_cnt + 1;
      end
      exp_b = en_n2 ? 4'b0000 : 4'(1 << m_sel);
      tick();
      checks++; if (b2 !== exp_b) begin errors++; $display("FAIL rand_b i=%0d got=%b exp=%b", i, b2, exp_b); end
      checks++; if (sel2 !== 2'(m_sel)) begin errors++; $display("FAIL rand_sel i=%0d got=%0d exp=%0d", i, sel2, m_sel); end
      checks++; if (wrap2 !== 1'(m_wrap)) begin errors++; $display("FAIL rand_wrap i=%0d got=%b exp=%0d", i, wrap2, m_wrap); end
    end
  endtask

  initial begin
    rst = 1'b0;
    en_n2 = 1'b1; mode2 = 1'b0; a2 = 2'd0; presc2 = 16'd0;
    en_n3 = 1'b1; mode3 = 1'b0; a3 = 3'd0; presc3 = 16'd0;
    en_nl = 1'b1; model = 1'b0; al = 2'd0; prescl = 16'd0;
    #1;
    test_reset();
    test_direct();
    test_scan_n2_p2();
    test_scan_n3_p0();
    test_presc_change();
    test_active_low();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout bench did not finish");
    $fatal(1);
  end

endmodule
